// File: rtl/cla_pkg.sv
// Shared constants and lookahead helpers for the 16-bit carry-lookahead adder.
package cla_pkg;

  localparam int CLA_WIDTH   = 16;
  localparam int CLA_GROUP   = 4;
  localparam int CLA_NGROUPS = 4;

  // Four-term generate expression: g3 | p3 g2 | p3 p2 g1 | p3 p2 p1 g0.
  function automatic logic cla_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3]
         | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Flattened carries into positions 1..3 from a carry-in, no ripple.
  // Returns {c3, c2, c1}.
  function automatic logic [2:0] cla_lookahead(input logic [3:0] g,
                                               input logic [3:0] p,
                                               input logic       c);
    logic [2:0] cr;
    cr[0] = g[0] | (p[0] & c);
    cr[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    cr[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    return cr;
  endfunction

endpackage

// File: rtl/cla_4bit_group.sv
// One 4-bit lookahead group: local sum bits plus group generate/propagate.
module cla_4bit_group
  import cla_pkg::*;
(
  input  logic [CLA_GROUP-1:0] a,
  input  logic [CLA_GROUP-1:0] b,
  input  logic                 ci,
  output logic [CLA_GROUP-1:0] s,
  output logic                 G,
  output logic                 P
);

  logic [CLA_GROUP-1:0] g;
  logic [CLA_GROUP-1:0] p;
  logic [CLA_GROUP-1:0] c;

  // Bit generate/propagate, flattened internal carries and sum bits.
  always_comb begin
    g = a & b;
    p = a ^ b;
    c = {cla_lookahead(g, p, ci), ci};
    s = p ^ c;
    G = cla_gen(g, p);
    P = &p;
  end

endmodule

// File: rtl/cla_16bits.sv
// 16-bit two-level carry-lookahead adder with registered sum and carry-out.
module cla_16bits
  import cla_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CLA_WIDTH-1:0] a,
  input  logic [CLA_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [CLA_WIDTH-1:0] sum,
  output logic                 cout
);

  logic [CLA_NGROUPS-1:0] grp_g;
  logic [CLA_NGROUPS-1:0] grp_p;
  logic [CLA_NGROUPS:0]   grp_c;
  logic [CLA_WIDTH-1:0]   sum_d;
  logic [CLA_WIDTH-1:0]   sum_q;
  logic                   cout_d;
  logic                   cout_q;

  for (genvar k = 0; k < CLA_NGROUPS; k++) begin : g_grp
    cla_4bit_group u_grp (
      .a  (a[k*CLA_GROUP +: CLA_GROUP]),
      .b  (b[k*CLA_GROUP +: CLA_GROUP]),
      .ci (grp_c[k]),
      .s  (sum_d[k*CLA_GROUP +: CLA_GROUP]),
      .G  (grp_g[k]),
      .P  (grp_p[k])
    );
  end

  // Second-level lookahead: every group carry-in is derived directly from cin.
  always_comb begin
    grp_c[0]   = cin;
    grp_c[3:1] = cla_lookahead(grp_g, grp_p, cin);
    grp_c[4]   = cla_gen(grp_g, grp_p) | ((&grp_p) & cin);
    cout_d     = grp_c[4];
  end

  // Result register, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_cla_16bits.sv
// Self-checking bench for cla_16bits: directed cases, async reset, random regression.
module tb_cla_16bits;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] a   = '0;
  logic [15:0] b   = '0;
  logic        cin = 1'b0;
  logic [15:0] sum;
  logic        cout;

  int passed = 0;
  int total  = 0;

  logic [16:0] exp_q;

  cla_16bits dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c);
    int unsigned r;
    r = int'(x) + int'(y) + int'(c);
    return r[16:0];
  endfunction

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed {cout,sum}=%05h expected %05h", tag, obs, expv);
  endtask

  // Drive operands, capture on the next edge, then compare just after it.
  task automatic step(input string tag, input logic [15:0] x, input logic [15:0] y,
                      input logic c);
    a = x; b = y; cin = c;
    exp_q = model(x, y, c);
    @(posedge clk);
    #1;
    check(tag, {cout, sum}, exp_q);
  endtask

  initial begin
    rst = 1'b1;
    a   = 16'($urandom);
    b   = 16'($urandom);
    cin = 1'($urandom);
    #1;
    check("reset_t0", {cout, sum}, 17'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held_edges", {cout, sum}, 17'h0);

    a = 16'h1357; b = 16'h2468; cin = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_after_reset", {cout, sum}, 17'h037C0);

    step("mixed_a", 16'hF0F0, 16'hCCCC, 1'b0);
    check("mixed_a_const", {cout, sum}, 17'h1BDBC);
    step("mixed_b", 16'hF0F0, 16'hF0CC, 1'b1);
    check("mixed_b_const", {cout, sum}, 17'h1E1BD);
    step("full_carry", 16'hFFFF, 16'h0000, 1'b1);
    check("full_carry_const", {cout, sum}, 17'h10000);
    step("carry_to_msb", 16'h7FFF, 16'h0001, 1'b0);
    check("carry_to_msb_const", {cout, sum}, 17'h08000);
    step("zero", 16'h0000, 16'h0000, 1'b0);
    step("all_ones", 16'hFFFF, 16'hFFFF, 1'b1);
    check("all_ones_const", {cout, sum}, 17'h1FFFF);

    step("pre_reset", 16'h1234, 16'h1111, 1'b0);
    check("pre_reset_const", {cout, sum}, 17'h02345);
    #2;
    rst = 1'b1;
    #1;
    check("async_clear", {cout, sum}, 17'h0);
    a = 16'hABCD; b = 16'h8888; cin = 1'b1;
    rst = 1'b0;
    #1;
    check("no_edge_yet", {cout, sum}, 17'h0);
    @(posedge clk);
    #1;
    check("after_release", {cout, sum}, 17'h13456);

    for (int i = 0; i < 10000; i++) begin
      step("random", 16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
